// File: rtl/sort_pkg.sv
// ============================================================================
// Module  : sort_pkg
// Brief   : Constants, element type and unloader state encoding shared by the
//           8-lane bubble sorter and its result unloader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sort_pkg;
    localparam int DATA_W = 4;
    localparam int N      = 8;
    localparam int IDX_W  = $clog2(N);

    typedef logic [DATA_W-1:0] elem_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } unload_state_t;
endpackage

`default_nettype wire

// File: rtl/sort_order_chk.sv
// ============================================================================
// Module  : sort_order_chk
// Brief   : Sticky monotonic-order checker on the unloader's transferred beats.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sort_order_chk
    import sort_pkg::*;
#(
    parameter int DATA_W = sort_pkg::DATA_W,
    parameter int IDX_W  = sort_pkg::IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              xfer,
    input  logic [DATA_W-1:0] data,
    input  logic [IDX_W-1:0]  index,
    output logic              err_order
);

    logic [DATA_W-1:0] prev_q, prev_d;
    logic              err_q, err_d;

    always_comb begin
        prev_d = prev_q;
        err_d  = err_q;
        if (xfer) begin
            prev_d = data;
            if ((index != '0) && (data < prev_q)) begin
                err_d = 1'b1;
            end
        end
        // A fresh capture starts a new result, so it wins over a late violation.
        if (clear) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            err_q  <= err_d;
        end
    end

    assign err_order = err_q;

endmodule

`default_nettype wire

// File: rtl/sort_unloader.sv
// ============================================================================
// Module  : sort_unloader
// Brief   : Captures the 8 sorted lanes on done and streams them out lane 0
//           first over valid/ready. Optional order checker enabled by the
//           macro SORT_UNLOADER_ORDER_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sort_unloader
    import sort_pkg::*;
#(
    parameter int DATA_W = sort_pkg::DATA_W,
    parameter int N      = sort_pkg::N,
    parameter int IDX_W  = sort_pkg::IDX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                done,
    input  logic [N*DATA_W-1:0] sort_bus,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATA_W-1:0]   m_data,
    output logic [IDX_W-1:0]    m_index,
    output logic                m_last,
    output logic                busy,
    output logic                drop,
    output logic                err_order
);

    typedef logic [N-1:0][DATA_W-1:0] buf_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    unload_state_t     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    buf_t              buf_q, buf_d;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [IDX_W-1:0]  m_index_q, m_index_d;
    logic              m_last_q, m_last_d;
    logic              drop_q, drop_d;
    logic              capture;
    logic              xfer;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        capture = 1'b0;
        drop_d  = 1'b0;
        xfer    = m_valid_q && m_ready;

        case (state_q)
            IDLE: begin
                capture = done;
            end
            STREAM: begin
                if (xfer && (idx_q == LAST_IDX)) begin
                    // done on the final beat chains the next result with no bubble
                    if (done) begin
                        capture = 1'b1;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end else begin
                    if (xfer) begin
                        idx_d = idx_q + 1'b1;
                    end
                    drop_d = done;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            buf_d   = buf_t'(sort_bus);
            idx_d   = '0;
            state_d = STREAM;
        end

        // Outputs are computed from next-state so every port comes from a flop.
        m_valid_d = (state_d == STREAM);
        m_index_d = m_valid_d ? idx_d : '0;
        m_data_d  = m_valid_d ? buf_d[idx_d] : '0;
        m_last_d  = m_valid_d && (idx_d == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            buf_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_index_q <= '0;
            m_last_q  <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_index_q <= m_index_d;
            m_last_q  <= m_last_d;
            drop_q    <= drop_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_index = m_index_q;
    assign m_last  = m_last_q;
    assign busy    = (state_q == STREAM);
    assign drop    = drop_q;

`ifdef SORT_UNLOADER_ORDER_CHECK_EN
    sort_order_chk #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_order_chk (
        .clk       (clk),
        .rst       (rst),
        .clear     (capture),
        .xfer      (xfer),
        .data      (m_data_q),
        .index     (m_index_q),
        .err_order (err_order)
    );
`else
    assign err_order = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sort_unloader.sv
// ============================================================================
// Module  : tb_sort_unloader
// Brief   : Scoreboard bench for sort_unloader: capture, backpressure,
//           back-to-back, drop, mid-stream reset and order checking.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sort_unloader;

    localparam int DW = 4;
    localparam int NL = 8;
    localparam int IW = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             done;
    logic [NL*DW-1:0] sort_bus;
    logic             m_valid;
    logic             m_ready;
    logic [DW-1:0]    m_data;
    logic [IW-1:0]    m_index;
    logic             m_last;
    logic             busy;
    logic             drop;
    logic             err_order;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    sort_unloader u_dut (
        .clk       (clk),
        .rst       (rst),
        .done      (done),
        .sort_bus  (sort_bus),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_index   (m_index),
        .m_last    (m_last),
        .busy      (busy),
        .drop      (drop),
        .err_order (err_order)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted beat must match the next expected {data,index,last}.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected: got data=%0d idx=%0d last=%0b, want no beat",
                         m_data, m_index, m_last);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if ({m_data, m_index, m_last} !== e) begin
                    bad++;
                    $display("FAIL beat: got data=%0d idx=%0d last=%0b, want data=%0d idx=%0d last=%0b",
                             m_data, m_index, m_last, e[7:4], e[3:1], e[0]);
                end
            end
        end
    end

    function automatic logic [NL*DW-1:0] mk(input logic [3:0] l0, l1, l2, l3,
                                            l4, l5, l6, l7);
        return {l7, l6, l5, l4, l3, l2, l1, l0};
    endfunction

    task automatic push_n(input logic [NL*DW-1:0] bus, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({bus[i*DW +: DW], 3'(i), (i == NL - 1)});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [NL*DW-1:0] bus);
        sort_bus = bus;
        done     = 1'b1;
        step();
        done     = 1'b0;
    endtask

    task automatic wait_idx(input logic [IW-1:0] target);
        int n = 0;
        while (!(m_valid && m_index == target) && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL wait_idx: timeout, got idx=%0d valid=%0b, want idx=%0d", m_index, m_valid, target);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL drain: timeout, got %0d beats pending, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; done = 1'b0; m_ready = 1'b0; sort_bus = '0;
        step();
        step();
        rst = 1'b0;
        total++;
        if ({m_valid, m_data, m_index, m_last, busy, drop, err_order} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {m_valid, m_data, m_index, m_last, busy, drop, err_order});
        end
        m_ready = 1'b1;
        step();
        total++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_quiet: got valid=%0b busy=%0b, want 0 0", m_valid, busy);
        end
    endtask

    task automatic test_capture();
        logic [NL*DW-1:0] b;
        int cyc = 0;
        b = mk(1, 2, 3, 4, 5, 6, 7, 8);
        push_n(b, NL);
        m_ready = 1'b1;
        start(b);
        total++;
        if (m_valid !== 1'b1 || m_index !== 3'd0 || m_data !== 4'd1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL capture_first: got valid=%0b idx=%0d data=%0d busy=%0b, want 1 0 1 1",
                     m_valid, m_index, m_data, busy);
        end
        while (m_valid && cyc < 20) begin
            step();
            cyc++;
        end
        total++;
        if (cyc != NL) begin
            bad++;
            $display("FAIL capture_len: got %0d valid cycles, want %0d", cyc, NL);
        end
        total++;
        if (busy !== 1'b0 || m_last !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL capture_end: got busy=%0b last=%0b pending=%0d, want 0 0 0",
                     busy, m_last, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [NL*DW-1:0] b;
        b = mk(1, 2, 3, 4, 5, 6, 7, 8);
        push_n(b, NL);
        m_ready = 1'b1;
        start(b);
        wait_idx(3'd2);
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (m_valid !== 1'b1 || m_data !== 4'd3 || m_index !== 3'd2 || m_last !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got valid=%0b data=%0d idx=%0d, want 1 3 2",
                         k, m_valid, m_data, m_index);
            end
        end
        m_ready = 1'b1;
        drain();
    endtask

    task automatic test_back_to_back();
        logic [NL*DW-1:0] b1, b2;
        b1 = mk(1, 2, 3, 4, 5, 6, 7, 8);
        b2 = mk(9, 8, 7, 6, 5, 4, 3, 2);
        push_n(b1, NL);
        m_ready = 1'b1;
        start(b1);
        wait_idx(3'd4);
        sort_bus = {NL*DW{1'b1}};
        done     = 1'b1;
        step();
        done     = 1'b0;
        total++;
        if (drop !== 1'b1) begin
            bad++;
            $display("FAIL drop_pulse: got drop=%0b, want 1", drop);
        end
        step();
        total++;
        if (drop !== 1'b0) begin
            bad++;
            $display("FAIL drop_one_cycle: got drop=%0b, want 0", drop);
        end
        wait_idx(3'd7);
        push_n(b2, NL);
        sort_bus = b2;
        done     = 1'b1;
        step();
        done     = 1'b0;
        total++;
        if (m_valid !== 1'b1 || m_index !== 3'd0 || m_data !== 4'd9 || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_no_gap: got valid=%0b idx=%0d data=%0d busy=%0b, want 1 0 9 1",
                     m_valid, m_index, m_data, busy);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic [NL*DW-1:0] b;
        b = mk(1, 2, 3, 4, 5, 6, 7, 8);
        push_n(b, 5);
        m_ready = 1'b1;
        start(b);
        wait_idx(3'd5);
        m_ready = 1'b0;
        rst     = 1'b1;
        step();
        rst     = 1'b0;
        total++;
        if ({m_valid, m_data, m_index, m_last, busy, drop, err_order} !== 13'd0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL reset_mid: got %b pending=%0d, want all zero and 0 pending",
                     {m_valid, m_data, m_index, m_last, busy, drop, err_order}, exp_q.size());
        end
        push_n(b, NL);
        m_ready = 1'b1;
        start(b);
        total++;
        if (m_valid !== 1'b1 || m_index !== 3'd0 || m_data !== 4'd1) begin
            bad++;
            $display("FAIL reset_restart: got valid=%0b idx=%0d data=%0d, want 1 0 1",
                     m_valid, m_index, m_data);
        end
        drain();
    endtask

    task automatic test_order();
        logic [NL*DW-1:0] b, b1;
        logic exp_err;
        int n = 0;
        b  = mk(1, 2, 3, 7, 5, 6, 7, 8);
        b1 = mk(1, 2, 3, 4, 5, 6, 7, 8);
        push_n(b, NL);
        m_ready = 1'b1;
        start(b);
        while (m_valid && n < 20) begin
`ifdef SORT_UNLOADER_ORDER_CHECK_EN
            exp_err = (m_index >= 3'd5);
`else
            exp_err = 1'b0;
`endif
            total++;
            if (err_order !== exp_err) begin
                bad++;
                $display("FAIL order_flag idx=%0d: got err=%0b, want %0b", m_index, err_order, exp_err);
            end
            step();
            n++;
        end
`ifdef SORT_UNLOADER_ORDER_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        total++;
        if (err_order !== exp_err) begin
            bad++;
            $display("FAIL order_sticky: got err=%0b, want %0b", err_order, exp_err);
        end
        push_n(b1, NL);
        start(b1);
        total++;
        if (err_order !== 1'b0) begin
            bad++;
            $display("FAIL order_clear: got err=%0b, want 0", err_order);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_capture();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_order();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
